// File: rtl/notch_bank_sched.sv
// notch_bank_sched
// Time-multiplexed biquad notch engine. One multiplier and one accumulator
// serve NCH channels; each accepted sample runs five MAC taps, then the
// saturated result is emitted and that channel's delay lines advance.
//
// Ports
//   CLK, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   sample handshake; in_ready depends on state only
//   in_ch, in_data      channel and signed sample x[n]
//   out_valid           one-cycle result pulse, no back-pressure
//   out_ch, out_data    channel and saturated y[n]
//   cfg_we, cfg_addr    coefficient write, address {channel, idx}
//                       idx 0..4 = b0, b1, b2, a1, a2
//   cfg_data            coefficient value (signed, FRAC fraction bits)
//   ch_clr              zero delay lines of cfg_addr's channel
//   cfg_err             one-cycle pulse when a write/clear is rejected
//
// state | meaning
// IDLE  | in_ready high, waiting for a sample
// MAC   | one product per cycle, taps 0..4; result issued on tap 4

module notch_bank_sched #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int FRAC  = 14
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [$clog2(NCH)-1:0]     in_ch,
    input  logic signed [WIDTH-1:0]    in_data,
    output logic                       out_valid,
    output logic [$clog2(NCH)-1:0]     out_ch,
    output logic signed [WIDTH-1:0]    out_data,
    input  logic                       cfg_we,
    input  logic [$clog2(NCH)+2:0]     cfg_addr,
    input  logic signed [WIDTH-1:0]    cfg_data,
    output logic                       cfg_err,
    input  logic                       ch_clr
);

    localparam int CHW  = $clog2(NCH);
    localparam int ACCW = 2 * WIDTH + 3;

    localparam logic signed [WIDTH-1:0] COEF_ONE =
        {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [ACCW-1:0] SAT_MAX =
        {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN =
        {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_MAC} state_t;

    state_t                   state;
    logic [2:0]               tap;
    logic [CHW-1:0]           cur_ch;
    logic signed [WIDTH-1:0]  cur_x;
    logic signed [ACCW-1:0]   acc;

    logic signed [WIDTH-1:0]  coef_q [NCH][5];
    logic signed [WIDTH-1:0]  x1_q [NCH];
    logic signed [WIDTH-1:0]  x2_q [NCH];
    logic signed [WIDTH-1:0]  y1_q [NCH];
    logic signed [WIDTH-1:0]  y2_q [NCH];

    logic signed [WIDTH-1:0]   op_coef;
    logic signed [WIDTH-1:0]   op_data;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    prod_ext;
    logic signed [ACCW-1:0]    term;
    logic signed [ACCW-1:0]    acc_sum;
    logic signed [ACCW-1:0]    acc_shr;
    logic signed [WIDTH-1:0]   y_sat;

    logic [CHW-1:0] cfg_ch;
    logic [2:0]     cfg_idx;
    logic           cfg_busy_hit;
    logic           cfg_reject;
    logic           tap4_fire;

    // Operand select for the current tap.
    always_comb begin
        op_coef = '0;
        op_data = '0;
        case (tap)
            3'd0: begin op_coef = coef_q[cur_ch][0]; op_data = cur_x;        end
            3'd1: begin op_coef = coef_q[cur_ch][1]; op_data = x1_q[cur_ch]; end
            3'd2: begin op_coef = coef_q[cur_ch][2]; op_data = x2_q[cur_ch]; end
            3'd3: begin op_coef = coef_q[cur_ch][3]; op_data = y1_q[cur_ch]; end
            3'd4: begin op_coef = coef_q[cur_ch][4]; op_data = y2_q[cur_ch]; end
            default: begin op_coef = '0; op_data = '0; end
        endcase
    end

    // Feedback taps subtract. Accumulator headroom covers five full-scale
    // products, so the sum never wraps.
    always_comb begin
        prod     = op_coef * op_data;
        prod_ext = {{(ACCW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        term     = (tap >= 3'd3) ? -prod_ext : prod_ext;
        acc_sum  = acc + term;
        acc_shr  = acc_sum >>> FRAC;
        if (acc_shr > SAT_MAX)
            y_sat = {1'b0, {(WIDTH-1){1'b1}}};
        else if (acc_shr < SAT_MIN)
            y_sat = {1'b1, {(WIDTH-1){1'b0}}};
        else
            y_sat = acc_shr[WIDTH-1:0];
    end

    // Writes/clears aimed at the channel currently computing are refused so a
    // sample never sees a half-updated coefficient set or delay line.
    always_comb begin
        cfg_ch       = cfg_addr[CHW+2:3];
        cfg_idx      = cfg_addr[2:0];
        cfg_busy_hit = (state == S_MAC) && (cfg_ch == cur_ch);
        cfg_reject   = (cfg_we && (cfg_idx > 3'd4)) ||
                       ((cfg_we || ch_clr) && cfg_busy_hit);
        tap4_fire    = (state == S_MAC) && (tap == 3'd4);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            tap       <= '0;
            cur_ch    <= '0;
            cur_x     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            cfg_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            cfg_err   <= (cfg_we || ch_clr) && cfg_reject;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        cur_ch   <= in_ch;
                        cur_x    <= in_data;
                        acc      <= '0;
                        tap      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc_sum;
                    if (tap == 3'd4) begin
                        out_valid <= 1'b1;
                        out_ch    <= cur_ch;
                        out_data  <= y_sat;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        tap <= tap + 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                coef_q[c][0] <= COEF_ONE;
                for (int i = 1; i < 5; i++)
                    coef_q[c][i] <= '0;
            end
        end else if (cfg_we && !cfg_reject) begin
            coef_q[cfg_ch][cfg_idx] <= cfg_data;
        end
    end

    // A clear can never target the channel being updated on tap 4, since
    // that case is rejected above.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_clr && !cfg_reject && (cfg_ch == CHW'(c))) begin
                    x1_q[c] <= '0;
                    x2_q[c] <= '0;
                    y1_q[c] <= '0;
                    y2_q[c] <= '0;
                end else if (tap4_fire && (cur_ch == CHW'(c))) begin
                    x2_q[c] <= x1_q[c];
                    x1_q[c] <= cur_x;
                    y2_q[c] <= y1_q[c];
                    y1_q[c] <= y_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_notch_bank_sched.sv
// Bench for notch_bank_sched: a reference model predicts each result when
// the sample is accepted and queues it; a monitor pops and compares on
// every out_valid.

module tb_notch_bank_sched;

    localparam int W    = 16;
    localparam int NCH  = 4;
    localparam int FRAC = 14;

    logic                 CLK = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [1:0]           in_ch = '0;
    logic signed [W-1:0]  in_data = '0;
    logic                 out_valid;
    logic [1:0]           out_ch;
    logic signed [W-1:0]  out_data;
    logic                 cfg_we = 1'b0;
    logic [4:0]           cfg_addr = '0;
    logic signed [W-1:0]  cfg_data = '0;
    logic                 cfg_err;
    logic                 ch_clr = 1'b0;

    notch_bank_sched #(.WIDTH(W), .NCH(NCH), .FRAC(FRAC)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .ch_clr(ch_clr)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int n_vec = 0;
    int n_bad = 0;
    int err_cnt = 0;
    longint last_data = 0;

    typedef struct {
        logic [1:0] ch;
        longint     d;
    } exp_t;
    exp_t sb[$];

    longint cm [NCH][5];
    longint mx1 [NCH], mx2 [NCH], my1 [NCH], my2 [NCH];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            cm[c][0] = 64'sd1 <<< FRAC;
            for (int i = 1; i < 5; i++) cm[c][i] = 0;
            mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
        end
    endfunction

    function automatic longint model_step(input int c, input longint x);
        longint acc, y;
        acc = cm[c][0] * x + cm[c][1] * mx1[c] + cm[c][2] * mx2[c]
            - cm[c][3] * my1[c] - cm[c][4] * my2[c];
        y = acc >>> FRAC;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        mx2[c] = mx1[c]; mx1[c] = x;
        my2[c] = my1[c]; my1[c] = y;
        return y;
    endfunction

    always @(negedge CLK) begin
        if (rst_n) begin
            if (cfg_err) err_cnt++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_ch", longint'(out_ch), longint'(e.ch));
                    chk("out_data", longint'(out_data), e.d);
                    last_data = longint'(out_data);
                end
            end
        end
    end

    // Offers a sample, waits for acceptance, records the accept cycle.
    // Returns at accept edge + 1 time unit.
    int acc_cyc;
    task automatic send(input int ch, input longint x, input bit hold);
        int n;
        exp_t e;
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        in_data  = W'(x);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", longint'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        e.ch = 2'(ch);
        e.d  = model_step(ch, x);
        sb.push_back(e);
        @(posedge CLK); #1;
        acc_cyc = cyc;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic cfg_write(input int ch, input int idx, input int data);
        cfg_we   = 1'b1;
        cfg_addr = {2'(ch), 3'(idx)};
        cfg_data = W'(data);
        @(posedge CLK); #1;
        cfg_we = 1'b0;
    endtask

    task automatic clear_ch(input int ch);
        ch_clr   = 1'b1;
        cfg_addr = {2'(ch), 3'd0};
        @(posedge CLK); #1;
        ch_clr = 1'b0;
        mx1[ch] = 0; mx2[ch] = 0; my1[ch] = 0; my2[ch] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, prev;
        model_reset();

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        @(posedge CLK); #1;

        // Pass-through and exact latency on ch2
        send(2, 16'h1000, 0);
        chk("ready_after_accept", in_ready, 0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLK); #1;
            chk("ready_low_mac", in_ready, 0);
            chk("out_valid_early", out_valid, 0);
        end
        @(posedge CLK); #1;
        chk("out_valid_at_5", out_valid, 1);
        chk("ready_back_at_5", in_ready, 1);
        drain();
        chk("passthru_value", last_data, 4096);

        // FIR on ch0
        cfg_write(0, 0, 8192); cm[0][0] = 8192;
        cfg_write(0, 1, 8192); cm[0][1] = 8192;
        send(0, 1000, 0); drain();
        chk("fir_first", last_data, 500);
        send(0, 2000, 0); drain();
        chk("fir_second", last_data, 1500);
        clear_ch(0);
        send(0, 2000, 0); drain();
        chk("fir_after_clr", last_data, 1000);

        // Recursion and saturation on ch1
        cfg_write(1, 0, 16384); cm[1][0] = 16384;
        cfg_write(1, 3, -16384); cm[1][3] = -16384;
        send(1, 100, 0); drain();
        send(1, 0, 0); drain();
        send(1, 0, 0); drain();
        chk("iir_hold", last_data, 100);
        cfg_write(1, 0, 32767); cm[1][0] = 32767;
        clear_ch(1);
        send(1, 30000, 0); drain();
        chk("sat_pos", last_data, 32767);
        clear_ch(1);
        send(1, -32768, 0); drain();
        chk("sat_neg", last_data, -32768);

        // Channel isolation with in_valid held high
        cfg_write(0, 1, 0); cm[0][1] = 0;
        clear_ch(0);
        send(0, 4000, 1);
        prev = acc_cyc;
        for (int k = 0; k < 6; k++) begin
            if (k[0]) send(0, 1200 * k - 3000, (k != 5));
            else      send(3, 7000 - 2500 * k, 1);
            chk("accept_spacing", acc_cyc - prev, 6);
            prev = acc_cyc;
        end
        drain();

        // Config errors
        e0 = err_cnt;
        cfg_write(0, 6, 1234);
        repeat (2) @(posedge CLK);
        #1;
        chk("err_idx6", err_cnt - e0, 1);
        send(0, 3000, 0); drain();

        cfg_write(1, 0, 16384); cm[1][0] = 16384;
        cfg_write(1, 3, 0); cm[1][3] = 0;
        clear_ch(1);
        e0 = err_cnt;
        send(1, 1000, 0);
        cfg_write(1, 0, 4096);
        drain();
        chk("err_busy_ch", err_cnt - e0, 1);
        send(1, 2000, 0); drain();
        chk("busy_write_ignored", last_data, 2000);

        e0 = err_cnt;
        send(1, 500, 0);
        cfg_write(0, 0, 4096); cm[0][0] = 4096;
        drain();
        chk("other_ch_write_ok", err_cnt - e0, 0);
        clear_ch(0);
        send(0, 4000, 0); drain();
        chk("other_ch_write_used", last_data, 1000);

        // Reset mid-MAC
        send(2, 500, 0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (2) @(posedge CLK);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        send(0, 1234, 0); drain();
        chk("post_rst_passthru", last_data, 1234);
        send(1, -777, 0); drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/notch_bank_sched.md
# notch_bank_sched

Time-multiplexed IIR biquad notch engine for the DFE. It serves NCH independent channels from one multiplier and one accumulator. A 5-tap FSM performs the MACs for each sample in sequence, and per-channel coefficients and delay lines are held in register banks. It sits after the decimation chain and replaces one fixed-coefficient notch instance per channel with a single shared, runtime-programmable datapath.

## Interface
- WIDTH, 16: sample and coefficient width, signed.
- NCH, 4: number of channels, power of two, at least 2.
- FRAC, 14: coefficient fraction bits (S16.14 coefficients).
- CLK, in, 1: clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- in_valid, in, 1: input sample offered.
- in_ready, out, 1: engine idle and able to accept a sample.
- in_ch, in, log2(NCH): channel of the offered sample.
- in_data, in, WIDTH: offered sample x[n].
- out_valid, out, 1: one-cycle pulse when the result is valid.
- out_ch, out, log2(NCH): channel of the result.
- out_data, out, WIDTH: y[n], saturated.
- cfg_we, in, 1: coefficient write strobe.
- cfg_addr, in, log2(NCH)+3: {channel, idx}, where idx 0..4 selects b0, b1, b2, a1, a2.
- cfg_data, in, WIDTH: coefficient value.
- cfg_err, out, 1: one-cycle pulse when a write is rejected.
- ch_clr, in, 1: clear the delay lines of the channel on cfg_addr's channel field.

## Operation
- Filter equation: y[n] = (b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2]) >>> FRAC.
- FSM states:
  - IDLE: in_ready=1.
  - The edge where in_valid && in_ready are both high latches in_ch and in_data, clears the accumulator, sets tap=0 and moves to MAC.
  - MAC: one product per cycle, in tap order 0 b0·x, 1 b1·x1, 2 b2·x2, 3 −a1·y1, 4 −a2·y2.
  - On the tap-4 edge the FSM returns to IDLE.
- Accumulator width: 2·WIDTH+3, signed; no overflow is possible.
- Result: acc >>> FRAC (arithmetic shift), then saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Tap-4 edge actions:
  - out_data takes the saturated result; out_ch is set; out_valid=1 for one cycle.
  - The latched channel's delay lines update: x2←x1, x1←x, y2←y1, y1←saturated y.
- Feedback uses the saturated y.
- Other channels' state is untouched by a sample on one channel.
- Coefficient writes:
  - A write applies on the edge where cfg_we is high.
  - It is rejected, with cfg_err pulsed on the next cycle and no change made, when:
    - idx is 5..7, or
    - the target channel equals the channel currently in MAC.
  - Writes to other channels during MAC are accepted.
- ch_clr:
  - Zeroes x1, x2, y1 and y2 of the addressed channel.
  - It is ignored, with cfg_err pulsed, if that channel is in MAC.
  - If cfg_we and ch_clr are both high, both act; rejection is evaluated once.

## Timing
- Reset (asynchronous) sets:
  - FSM to IDLE, in_ready=1.
  - out_valid=0, out_ch=0, out_data=0, cfg_err=0.
  - All delay lines to 0.
  - Per-channel coefficients to pass-through: b0=2^FRAC, b1=b2=a1=a2=0.
- Latency: input accepted at edge E; out_valid is high in the cycle after edge E+5.
- in_ready falls after edge E and rises after edge E+5, so the next accept is at E+6 at the earliest.
- Throughput: one sample per 6 cycles.
- in_ready is a function of state only; it never depends combinationally on in_valid.
- No output back-pressure: out_valid is a pulse that downstream logic must capture.
- Asserting rst_n mid-MAC aborts the sample with no out_valid and restores the reset values above.
- A coefficient write accepted at edge W is used by any sample whose MAC for that tap occurs after W.

## Test plan
- Reset pass-through: after reset, ch2 in_data=0x1000 → out_valid exactly 5 cycles after the accept edge, out_ch=2, out_data=0x1000; in_ready low for 5 cycles.
- FIR programming, ch0:
  - Write b0=8192 and b1=8192.
  - Send inputs 1000 then 2000 → outputs 500 then 1500.
  - Then ch_clr ch0 and send 2000 → output 1000.
- Recursion and saturation, ch1:
  - Set b0=16384 and a1=−16384, then send 100, 0, 0 → outputs 100, 100, 100.
  - Set b0=32767, clear ch1, then send 30000 → out_data=32767.
  - Clear ch1, then send −32768 → out_data=−32768.
- Channel isolation: interleave ch0 with b0=8192 and ch3 in pass-through, with in_valid held high → accepts exactly every 6 cycles; ch3 outputs equal its inputs.
- Config errors:
  - idx=6 → cfg_err pulse, no coefficient changes.
  - Write to ch1 while ch1 is in MAC → cfg_err, old coefficient still used.
  - Write to ch0 during ch1's MAC → accepted, no cfg_err.
- Reset mid-operation: deassert rst_n at MAC tap 2 → no out_valid; after release, coefficients are back to pass-through and the next sample passes through unchanged.
